// File: rtl/mul_div_sequencer.sv
// Multi-cycle HI/LO multiply/divide sequencer: shift-add multiplier and restoring divider,
// one bit per enabled clock edge, plus MTHI/MTLO writes and CPU stall generation.
module mul_div_sequencer #(
    parameter int DataWidth = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [DataWidth-1:0] a,
    input  logic [DataWidth-1:0] b,
    input  logic                 read,
    output logic                 ready,
    output logic                 busy,
    output logic                 stall,
    output logic                 done,
    output logic                 divByZero,
    output logic [DataWidth-1:0] high,
    output logic [DataWidth-1:0] low
);
    localparam int W    = DataWidth;
    localparam int CntW = $clog2(DataWidth);
    localparam logic [CntW-1:0] CntLast = CntW'(DataWidth - 1);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     high_q, high_d;
    logic [W-1:0]     low_q, low_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             isdiv_q, isdiv_d;

    logic             signed_op;
    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;
    logic [W-1:0]     div_sub;
    logic             div_ge;
    logic [2*W-1:0]   prod;
    logic [W-1:0]     quo;
    logic [W-1:0]     rem;

    function automatic logic [W-1:0] cneg(input logic [W-1:0] v, input logic neg);
        return neg ? (~v) + W'(1) : v;
    endfunction

    function automatic logic [2*W-1:0] cneg2(input logic [2*W-1:0] v, input logic neg);
        return neg ? (~v) + (2*W)'(1) : v;
    endfunction

    // acc holds {partial high, remaining multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
    assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_sub   = div_shift[W-1:0] - opnd_q;
    assign prod      = cneg2(acc_q, qsign_q);
    assign quo       = cneg(acc_q[W-1:0], qsign_q);
    assign rem       = cneg(acc_q[2*W-1:W], rsign_q);
    assign signed_op = ~op[0];

    always_comb begin
        state_d = state_q;
        high_d  = high_q;
        low_d   = low_q;
        done_d  = done_q;
        dbz_d   = dbz_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        isdiv_d = isdiv_q;
        if (enable) begin
            done_d = 1'b0;
            dbz_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            high_d = a;
                        end else if (op == OP_MTLO) begin
                            low_d = a;
                        end else if (!op[2]) begin
                            if (op[1] && (b == {W{1'b0}})) begin
                                dbz_d = 1'b1;
                            end else begin
                                acc_d   = {{W{1'b0}}, cneg(a, signed_op & a[W-1])};
                                opnd_d  = cneg(b, signed_op & b[W-1]);
                                qsign_d = signed_op & (a[W-1] ^ b[W-1]);
                                rsign_d = signed_op & a[W-1];
                                isdiv_d = op[1];
                                cnt_d   = CntLast;
                                state_d = op[1] ? DIV : MUL;
                            end
                        end
                    end
                end
                MUL: begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                    if (cnt_q == '0) state_d = FIXUP;
                    else             cnt_d   = cnt_q - CntW'(1);
                end
                DIV: begin
                    acc_d = {(div_ge ? div_sub : div_shift[W-1:0]), acc_q[W-2:0], div_ge};
                    if (cnt_q == '0) state_d = FIXUP;
                    else             cnt_d   = cnt_q - CntW'(1);
                end
                FIXUP: begin
                    if (isdiv_q) begin
                        high_d = rem;
                        low_d  = quo;
                    end else begin
                        high_d = prod[2*W-1:W];
                        low_d  = prod[W-1:0];
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            high_q  <= '0;
            low_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            isdiv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            high_q  <= high_d;
            low_q   <= low_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            isdiv_q <= isdiv_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign ready     = ~busy;
    assign stall     = busy & (start | read);
    assign done      = done_q;
    assign divByZero = dbz_q;
    assign high      = high_q;
    assign low       = low_q;
endmodule

// File: tb/tb_mul_div_sequencer.sv
// Scoreboard bench for mul_div_sequencer: expected HI/LO pairs are queued at issue
// and popped when the done pulse appears; inputs change and outputs are sampled on negedge.
module tb_mul_div_sequencer;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset, enable, start, read;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         ready, busy, stall, done, divByZero;
    logic [W-1:0] high, low;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2*W-1:0] sb_q[$];

    mul_div_sequencer #(.DataWidth(W)) dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start), .op(op),
        .a(a), .b(b), .read(read), .ready(ready), .busy(busy), .stall(stall),
        .done(done), .divByZero(divByZero), .high(high), .low(low)
    );

    always #5 clock = ~clock;

    function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] sx, sy, p;
        logic signed [W-1:0]   xs, ys, q, r;
        sx = {{W{x[W-1]}}, x};
        sy = {{W{y[W-1]}}, y};
        xs = x;
        ys = y;
        case (o)
            3'd0: begin p = sx * sy; return p; end
            3'd1: return {{W{1'b0}}, x} * {{W{1'b0}}, y};
            3'd2: begin
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = xs / ys;
                r = xs % ys;
                return {r, q};
            end
            default: return {x % y, x / y};
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int busy_cyc);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) busy_cyc++;
            lat++;
            @(negedge clock);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; start = 1'b0; read = 1'b0; op = 3'd0; a = '0; b = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({busy, ready, done, divByZero} !== 4'b0100) begin
            n_bad++; $display("FAIL reset_ctrl got %b want 0100", {busy, ready, done, divByZero});
        end
        n_cmp++;
        if ({high, low} !== 64'h0) begin
            n_bad++; $display("FAIL reset_hilo got %h want 0", {high, low});
        end
    endtask

    task automatic test_multu;
        int lat, bc;
        logic [2*W-1:0] exp;
        sb_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, lat, bc);
        n_cmp++;
        if (lat !== 33) begin n_bad++; $display("FAIL multu_latency got %0d want 33", lat); end
        n_cmp++;
        if (bc !== 33) begin n_bad++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
        exp = sb_q.pop_front();
        n_cmp++;
        if ({high, low} !== exp) begin n_bad++; $display("FAIL multu_result got %h want %h", {high, low}, exp); end
        @(negedge clock);
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL done_single_pulse got %b want 0", done); end
    endtask

    task automatic test_mult_div;
        int lat, bc;
        logic [2*W-1:0] exp;
        logic [2:0]   ops[5] = '{3'd0, 3'd0, 3'd2, 3'd3, 3'd2};
        logic [W-1:0] as[5]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [W-1:0] bs[5]  = '{32'd7, 32'h8000_0000, 32'd2, 32'd2, 32'hFFFF_FFFF};
        logic [2*W-1:0] ex[5] = '{{32'hFFFF_FFFF, 32'hFFFF_FFEB}, {32'h4000_0000, 32'h0},
                                  {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h1, 32'h3},
                                  {32'h0, 32'h8000_0000}};
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(ex[i]);
            run_op(ops[i], as[i], bs[i], lat, bc);
            exp = sb_q.pop_front();
            n_cmp++;
            if ({high, low} !== exp || lat !== 33) begin
                n_bad++; $display("FAIL plan_case%0d got %h lat %0d want %h lat 33", i, {high, low}, lat, exp);
            end
        end
    endtask

    task automatic test_random;
        int lat, bc;
        logic [2*W-1:0] exp;
        logic [2:0] o;
        logic [W-1:0] x, y;
        for (int i = 0; i < 8; i++) begin
            o = 3'(i % 4);
            x = $urandom;
            y = (i >= 4) ? ($urandom & 32'h0000_FFFF) : $urandom;
            if (y == '0) y = 32'd3;
            sb_q.push_back(model(o, x, y));
            run_op(o, x, y, lat, bc);
            exp = sb_q.pop_front();
            n_cmp++;
            if ({high, low} !== exp) begin
                n_bad++; $display("FAIL random%0d op %0d a %h b %h got %h want %h", i, o, x, y, {high, low}, exp);
            end
        end
    endtask

    task automatic test_div_by_zero;
        op = 3'd4; a = 32'h11; start = 1'b1;
        @(negedge clock);
        op = 3'd5; a = 32'h22;
        @(negedge clock);
        start = 1'b0;
        n_cmp++;
        if ({high, low, busy, done} !== {32'h11, 32'h22, 2'b00}) begin
            n_bad++; $display("FAIL mthi_mtlo got %h %h busy %b done %b want 11 22 0 0", high, low, busy, done);
        end
        op = 3'd2; a = 32'd5; b = 32'd0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_cmp++;
        if ({divByZero, done, busy} !== 3'b100) begin
            n_bad++; $display("FAIL dbz_flags got %b want 100", {divByZero, done, busy});
        end
        n_cmp++;
        if ({high, low} !== {32'h11, 32'h22}) begin
            n_bad++; $display("FAIL dbz_hilo got %h want 0000001100000022", {high, low});
        end
        @(negedge clock);
        n_cmp++;
        if ({divByZero, busy} !== 2'b00) begin
            n_bad++; $display("FAIL dbz_pulse_end got %b want 00", {divByZero, busy});
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bad;
        logic [2*W-1:0] exp;
        sb_q.push_back({32'h0, 32'd15});
        op = 3'd1; a = 32'd3; b = 32'd5; start = 1'b1;
        @(negedge clock);
        op = 3'd1; a = 32'd6; b = 32'd7; read = 1'b1;
        cyc = 0; bad = 0;
        while (done !== 1'b1 && cyc < 200) begin
            if (stall !== 1'b1) bad++;
            cyc++;
            @(negedge clock);
        end
        n_cmp++;
        if (bad !== 0 || cyc !== 33) begin
            n_bad++; $display("FAIL stall_while_busy got %0d unstalled of %0d want 0 of 33", bad, cyc);
        end
        n_cmp++;
        if ({stall, ready} !== 2'b01) begin
            n_bad++; $display("FAIL done_cycle_stall got stall %b ready %b want 0 1", stall, ready);
        end
        exp = sb_q.pop_front();
        n_cmp++;
        if ({high, low} !== exp) begin n_bad++; $display("FAIL b2b_first got %h want %h", {high, low}, exp); end
        sb_q.push_back({32'h0, 32'd42});
        @(negedge clock);
        start = 1'b0; read = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept busy got %b want 1", busy); end
        cyc = 1;
        @(negedge clock);
        while (done !== 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clock);
        end
        exp = sb_q.pop_front();
        n_cmp++;
        if ({high, low} !== exp || cyc !== 33) begin
            n_bad++; $display("FAIL b2b_second got %h lat %0d want %h lat 33", {high, low}, cyc, exp);
        end
    endtask

    task automatic test_reset_midop;
        int seen;
        op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, high, low} !== {1'b0, 64'h0}) begin
            n_bad++; $display("FAIL async_reset got busy %b hilo %h want 0 0", busy, {high, low});
        end
        #1 reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL no_done_after_reset got %0d pulses want 0", seen); end
        op = 3'd4; a = 32'h1234; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_cmp++;
        if (high !== 32'h1234) begin n_bad++; $display("FAIL mthi_after_reset got %h want 00001234", high); end
    endtask

    task automatic test_enable;
        int lat;
        logic [2*W-1:0] exp;
        sb_q.push_back(model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
        op = 3'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        a = '0; b = '0;
        repeat (5) @(negedge clock);
        enable = 1'b0;
        repeat (5) @(negedge clock);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL enable_hold_busy got %b want 1", busy); end
        enable = 1'b1;
        lat = 10;
        while (done !== 1'b1 && lat < 200) begin
            lat++;
            @(negedge clock);
        end
        n_cmp++;
        if (lat !== 38) begin n_bad++; $display("FAIL enable_latency got %0d want 38", lat); end
        exp = sb_q.pop_front();
        n_cmp++;
        if ({high, low} !== exp) begin n_bad++; $display("FAIL enable_result got %h want %h", {high, low}, exp); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_multu();
        test_mult_div();
        test_random();
        test_div_by_zero();
        test_back_to_back();
        test_reset_midop();
        test_enable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mul_div_sequencer.md
Name: mul_div_sequencer

Overview:
Multi-cycle sequencer for the MIPS HI/LO multiply/divide resource. It replaces single-cycle combinational multiply/divide with a shift-add multiplier and a restoring divider, each taking DataWidth iterations. It owns the HI/LO registers and handles MTHI/MTLO writes. It stalls the CPU when an MFHI/MFLO read or a new operation arrives while a computation is in flight.

Parameters:
DataWidth, 32, operand / HI / LO width in bits (even, ≥4)

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  global enable; when 0, every register holds its value
start  in  1  operation request, sampled on the rising edge while ready=1
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
a  in  DataWidth  rs operand (multiplicand / dividend / MTHI-MTLO data)
b  in  DataWidth  rt operand (multiplier / divisor)
read  in  1  CPU is executing MFHI/MFLO this cycle
ready  out  1  can accept start; equals ~busy
busy  out  1  state ≠ IDLE
stall  out  1  busy & (start | read), combinational
done  out  1  one-cycle pulse: HI/LO were just committed by MULT*/DIV*
divByZero  out  1  one-cycle pulse: DIV/DIVU with b=0 was accepted
high  out  DataWidth  HI register
low  out  DataWidth  LO register

Behaviour:
- Reset (async, any state): state=IDLE, high=low=0, done=divByZero=0, internal accumulators cleared. Any in-flight operation is discarded.
- enable=0: all registers, including done, divByZero and the iteration counter, hold their values. start is not accepted.
- States:
  - IDLE: waits for start.
  - MUL: iterating multiply.
  - DIV: iterating divide.
  - FIXUP: sign correction and HI/LO commit.
- Accept (edge E0, state IDLE, start=1, enable=1):
  - MTHI: high←a. MTLO: low←a. State stays IDLE; no done pulse.
  - MULT/DIV (signed): latch |a|, |b|, product/quotient sign = a[msb]^b[msb], remainder sign = a[msb]. MULTU/DIVU use raw values with both signs 0.
  - DIV/DIVU with b=0: HI/LO unchanged, state stays IDLE, divByZero=1 and done=0 for the cycle after E0.
  - Reserved op: ignored, no state change.
  - Otherwise the counter is loaded with DataWidth-1 and state→MUL or DIV.
- Iteration: one bit per edge, E1..E(DataWidth).
  - MUL is LSB-first shift-add into a 2·DataWidth accumulator.
  - DIV is MSB-first restoring: shift a dividend bit into the partial remainder, subtract the divisor when the result is non-negative, quotient bit = not-borrow.
  - The counter decrements each edge; at counter 0 state→FIXUP.
- FIXUP (edge E(DataWidth+1)):
  - Negate the product (2·DataWidth bits), quotient and remainder per the latched signs.
  - MUL: high←product[2W-1:W], low←product[W-1:0].
  - DIV: low←quotient, high←remainder.
  - State→IDLE; done=1 for the next cycle.
  - Total latency from accepting edge to HI/LO update is DataWidth+1 edges.
- INT_MIN / -1 (signed DIV): low=INT_MIN (magnitude wraps), high=0. No flag.
- Handshake:
  - start while busy is not accepted and stall=1. The CPU holds op/a/b/start until ready.
  - The done cycle has ready=1, so a back-to-back start is accepted on the edge ending the done cycle.
  - read while busy gives stall=1. In the done cycle, high/low already hold the new result, so stall=0.
- Operand capture: a and b are latched only at E0. Changes afterwards have no effect.

Test Plan:
1. MULTU, a=0xFFFFFFFF, b=2 → busy for 33 cycles, then done pulse; high=0x00000001, low=0xFFFFFFFE.
2. MULT, a=0xFFFFFFFD (-3), b=7 → high=0xFFFFFFFF, low=0xFFFFFFEB. Also MULT, a=0x80000000, b=0x80000000 → high=0x40000000, low=0.
3. DIV, a=-7, b=2 → low=0xFFFFFFFD, high=0xFFFFFFFF. DIVU, a=7, b=2 → low=3, high=1. DIV, a=0x80000000, b=-1 → low=0x80000000, high=0.
4. Preload high=0x11, low=0x22 via MTHI/MTLO, then DIV with b=0 → next cycle divByZero=1, busy never 1, high=0x11, low=0x22 unchanged.
5. Start MULTU 3×5 and assert read from cycle 2 → stall=1 every busy cycle, stall=0 in the done cycle with low=15. A second start held during busy is accepted exactly at the done cycle and finishes DataWidth+1 edges later.
6. Reset pulsed at iteration 10 of a DIVU → busy=0, high=low=0, no done pulse follows. Then MTHI 0x1234 → high=0x1234 after one edge. With enable=0 held for 5 cycles mid-MULTU, latency extends by exactly 5 cycles and the result is unchanged.
